// File: rtl/nes_clk_pkg.sv
// ----------------------------------------------------------------------------
// nes_clk_pkg: shared state type and constants for the NES clock sequencer
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package nes_clk_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    PPU_RUN   = 2'd1,
    CPU_RUN   = 2'd2,
    CPU_HOLD  = 2'd3
  } clk_state_e;

  localparam int unsigned CE_DIV_NTSC = 3;

endpackage

`default_nettype wire

// File: rtl/nes_sync_bit.sv
// ----------------------------------------------------------------------------
// nes_sync_bit: multi-flop synchronizer for one asynchronous level input
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module nes_sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/nes_clock_sequencer.sv
// ----------------------------------------------------------------------------
// nes_clock_sequencer: PLL lock qualification, PPU/CPU clock enables and
// ordered PPU-then-CPU reset release, plus CPU-only soft reset handling.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module nes_clock_sequencer
  import nes_clk_pkg::*;
#(
  parameter int unsigned SYNC_STAGES        = 2,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned CPU_RST_DELAY      = 16,
  parameter int unsigned SOFT_RST_MIN       = 8,
  parameter int unsigned CE_DIV             = CE_DIV_NTSC
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       soft_rst_req,
  output logic       ppu_ce,
  output logic       cpu_ce,
  output logic [1:0] phase,
  output logic       ppu_rst_n,
  output logic       cpu_rst_n,
  output logic       sys_ready
);

  localparam int unsigned LOCK_W    = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int unsigned PULSE_MAX = (CPU_RST_DELAY > SOFT_RST_MIN) ? CPU_RST_DELAY : SOFT_RST_MIN;
  localparam int unsigned PULSE_W   = $clog2(PULSE_MAX + 1);

  localparam logic [LOCK_W-1:0]  LOCK_TARGET = LOCK_W'(LOCK_STABLE_CYCLES);
  localparam logic [PULSE_W-1:0] PULSE_SAT   = PULSE_W'(PULSE_MAX);
  localparam logic [PULSE_W-1:0] CPU_DELAY   = PULSE_W'(CPU_RST_DELAY);
  localparam logic [PULSE_W-1:0] SOFT_MIN    = PULSE_W'(SOFT_RST_MIN);
  localparam logic [1:0]         PHASE_LAST  = 2'(CE_DIV - 1);

  logic lock_s;
  logic soft_s;

  nes_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_lock (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (pll_locked),
    .q_o   (lock_s)
  );

  nes_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_soft (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (soft_rst_req),
    .q_o   (soft_s)
  );

  clk_state_e         state_q, state_d;
  logic [LOCK_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic [PULSE_W-1:0] pulse_cnt_q, pulse_cnt_d, pulse_inc;
  logic [1:0]         phase_q, phase_d;
  logic               soft_prev_q;
  logic               ppu_ce_q, ppu_ce_d;
  logic               cpu_ce_q, cpu_ce_d;
  logic               ppu_rst_n_q, ppu_rst_n_d;
  logic               cpu_rst_n_q, cpu_rst_n_d;
  logic               sys_ready_q, sys_ready_d;

  always_comb begin
    state_d     = state_q;
    lock_cnt_d  = '0;
    pulse_cnt_d = pulse_cnt_q;
    phase_d     = '0;
    ppu_ce_d    = 1'b0;
    cpu_ce_d    = 1'b0;
    ppu_rst_n_d = 1'b0;
    cpu_rst_n_d = 1'b0;
    sys_ready_d = 1'b0;
    pulse_inc   = (pulse_cnt_q == PULSE_SAT) ? pulse_cnt_q : pulse_cnt_q + PULSE_W'(1);

    if (!lock_s) begin
      state_d     = WAIT_LOCK;
      pulse_cnt_d = '0;
    end else begin
      if (state_q != WAIT_LOCK) begin
        ppu_ce_d    = 1'b1;
        ppu_rst_n_d = 1'b1;
        // The first running cycle (ppu_ce still low) starts the phase at 0.
        phase_d     = (!ppu_ce_q || phase_q == PHASE_LAST) ? 2'd0 : phase_q + 2'd1;
        cpu_ce_d    = (phase_d == PHASE_LAST);
        cpu_rst_n_d = (state_q == CPU_RUN);
        sys_ready_d = (state_q == CPU_RUN);
      end

      case (state_q)
        WAIT_LOCK: begin
          pulse_cnt_d = '0;
          if (lock_cnt_q == LOCK_TARGET) begin
            state_d = PPU_RUN;
          end else begin
            lock_cnt_d = lock_cnt_q + LOCK_W'(1);
          end
        end
        PPU_RUN: begin
          if (cpu_ce_d) begin
            pulse_cnt_d = pulse_inc;
            if (pulse_inc >= CPU_DELAY) begin
              state_d     = CPU_RUN;
              pulse_cnt_d = '0;
            end
          end
        end
        CPU_RUN: begin
          pulse_cnt_d = '0;
          if (soft_s && !soft_prev_q) begin
            state_d = CPU_HOLD;
          end
        end
        CPU_HOLD: begin
          // Leaving on a pulse edge makes the CPU release land right after an enable.
          if (cpu_ce_d) begin
            pulse_cnt_d = pulse_inc;
            if (pulse_inc >= SOFT_MIN && !soft_s) begin
              state_d     = CPU_RUN;
              pulse_cnt_d = '0;
            end
          end
        end
        default: state_d = WAIT_LOCK;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WAIT_LOCK;
      lock_cnt_q  <= '0;
      pulse_cnt_q <= '0;
      phase_q     <= '0;
      soft_prev_q <= 1'b0;
      ppu_ce_q    <= 1'b0;
      cpu_ce_q    <= 1'b0;
      ppu_rst_n_q <= 1'b0;
      cpu_rst_n_q <= 1'b0;
      sys_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_cnt_q  <= lock_cnt_d;
      pulse_cnt_q <= pulse_cnt_d;
      phase_q     <= phase_d;
      soft_prev_q <= soft_s;
      ppu_ce_q    <= ppu_ce_d;
      cpu_ce_q    <= cpu_ce_d;
      ppu_rst_n_q <= ppu_rst_n_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      sys_ready_q <= sys_ready_d;
    end
  end

  assign ppu_ce    = ppu_ce_q;
  assign cpu_ce    = cpu_ce_q;
  assign phase     = phase_q;
  assign ppu_rst_n = ppu_rst_n_q;
  assign cpu_rst_n = cpu_rst_n_q;
  assign sys_ready = sys_ready_q;

endmodule

`default_nettype wire

// File: tb/tb_nes_clock_sequencer.sv
// ----------------------------------------------------------------------------
// tb_nes_clock_sequencer: directed scenarios checked against a timeline model
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_nes_clock_sequencer;

  localparam int SYNC  = 2;
  localparam int LOCK  = 8;
  localparam int DELAY = 4;
  localparam int SMIN  = 2;
  localparam int CEDIV = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       soft_rst_req = 1'b0;
  logic       ppu_ce, cpu_ce, ppu_rst_n, cpu_rst_n, sys_ready;
  logic [1:0] phase;

  nes_clock_sequencer #(
    .SYNC_STAGES        (SYNC),
    .LOCK_STABLE_CYCLES (LOCK),
    .CPU_RST_DELAY      (DELAY),
    .SOFT_RST_MIN       (SMIN),
    .CE_DIV             (CEDIV)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pll_locked   (pll_locked),
    .soft_rst_req (soft_rst_req),
    .ppu_ce       (ppu_ce),
    .cpu_ce       (cpu_ce),
    .phase        (phase),
    .ppu_rst_n    (ppu_rst_n),
    .cpu_rst_n    (cpu_rst_n),
    .sys_ready    (sys_ready)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  function automatic void chk(input string nm, input int act, input int want);
    n_chk++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, want, cyc);
    end
  endfunction

  // Timeline model: outputs follow from how long synced lock has been steady,
  // the edge at which the PPU was released, and the CPU reset mode.
  bit lkq[$];
  bit skq[$];
  int streak, rel, mode, hcnt;   // mode: 0 before first CPU release, 1 running, 2 held
  bit nxt_cr, ss_prev;
  int e_ppu, e_ce, e_ph, e_cr;

  always @(posedge clk) begin
    bit ls, ss, run, ce;
    cyc++;
    if (!rst_n) begin
      lkq.delete(); skq.delete();
      streak = 0; rel = 0; mode = 0; hcnt = 0; nxt_cr = 0; ss_prev = 0;
      e_ppu = 0; e_ce = 0; e_ph = 0; e_cr = 0;
    end else begin
      ls = (lkq.size() >= SYNC) ? lkq[0] : 1'b0;
      ss = (skq.size() >= SYNC) ? skq[0] : 1'b0;
      lkq.push_back(pll_locked);
      skq.push_back(soft_rst_req);
      if (lkq.size() > SYNC) void'(lkq.pop_front());
      if (skq.size() > SYNC) void'(skq.pop_front());
      streak = ls ? ((streak < 100000) ? streak + 1 : streak) : 0;
      // One edge to notice the count reached its target, one for the output register.
      if (streak == LOCK + 2) rel = cyc;
      run = (streak >= LOCK + 2);
      if (!run) begin
        e_ppu = 0; e_ce = 0; e_ph = 0; e_cr = 0;
        mode = 0; nxt_cr = 0; hcnt = 0;
      end else begin
        e_ppu = 1;
        e_ph  = (cyc - rel) % CEDIV;
        ce    = (e_ph == CEDIV - 1);
        e_ce  = ce;
        e_cr  = nxt_cr;
        case (mode)
          0: if (ce && (cyc - rel + 1) / CEDIV == DELAY) begin mode = 1; nxt_cr = 1; end
          1: if (ss && !ss_prev) begin mode = 2; hcnt = 0; nxt_cr = 0; end
             else nxt_cr = 1;
          default: begin
            if (ce) hcnt++;
            if (ce && hcnt >= SMIN && !ss) begin mode = 1; nxt_cr = 1; end
            else nxt_cr = 0;
          end
        endcase
      end
      ss_prev = ss;
    end
    #2;
    chk("ppu_ce",    ppu_ce,    e_ppu);
    chk("ppu_rst_n", ppu_rst_n, e_ppu);
    chk("cpu_ce",    cpu_ce,    e_ce);
    chk("phase",     phase,     e_ph);
    chk("cpu_rst_n", cpu_rst_n, e_cr);
    chk("sys_ready", sys_ready, e_cr);
  end

  // Captured outputs, indexed by edge number relative to the capture start.
  int c_prst[64], c_pce[64], c_cce[64], c_crst[64], c_rdy[64], c_ph[64];

  task automatic capture(input int n, input int so_on, input int so_off, input int lk_drop);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #2;
      c_prst[k] = ppu_rst_n; c_pce[k] = ppu_ce; c_cce[k] = cpu_ce;
      c_crst[k] = cpu_rst_n; c_rdy[k] = sys_ready; c_ph[k] = phase;
      if (k == so_on)  soft_rst_req = 1'b1;
      if (k == so_off) soft_rst_req = 1'b0;
      if (lk_drop >= 0 && k == lk_drop)     pll_locked = 1'b0;
      if (lk_drop >= 0 && k == lk_drop + 1) pll_locked = 1'b1;
    end
  endtask

  task automatic check_clean_lock(input string tag);
    chk({tag, " ppu_rst_n@10"}, c_prst[10], 0);
    chk({tag, " ppu_rst_n@11"}, c_prst[11], 1);
    chk({tag, " ppu_ce@11"},    c_pce[11],  1);
    chk({tag, " phase@12"},     c_ph[12],   1);
    chk({tag, " cpu_ce@12"},    c_cce[12],  0);
    chk({tag, " cpu_ce@13"},    c_cce[13],  1);
    chk({tag, " cpu_ce@16"},    c_cce[16],  1);
    chk({tag, " cpu_ce@19"},    c_cce[19],  1);
    chk({tag, " cpu_ce@22"},    c_cce[22],  1);
    chk({tag, " cpu_rst_n@22"}, c_crst[22], 0);
    chk({tag, " cpu_rst_n@23"}, c_crst[23], 1);
    chk({tag, " sys_ready@23"}, c_rdy[23],  1);
  endtask

  initial begin
    #1;
    chk("reset ppu_rst_n", ppu_rst_n, 0);
    chk("reset cpu_rst_n", cpu_rst_n, 0);
    chk("reset phase",     phase,     0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Clean lock.
    @(negedge clk); pll_locked = 1'b1;
    capture(30, -1, -1, -1);
    check_clean_lock("s1");

    // One-clock soft reset pulse in CPU_RUN.
    @(negedge clk); soft_rst_req = 1'b1;
    capture(12, -1, 0, -1);
    chk("s4 cpu_rst_n@2", c_crst[2], 1);
    chk("s4 cpu_rst_n@3", c_crst[3], 0);
    chk("s4 cpu_ce@4",    c_cce[4],  1);
    chk("s4 cpu_ce@7",    c_cce[7],  1);
    chk("s4 cpu_rst_n@7", c_crst[7], 0);
    chk("s4 cpu_rst_n@8", c_crst[8], 1);
    chk("s4 ppu_rst_n@5", c_prst[5], 1);
    chk("s4 phase@5",     c_ph[5],   0);

    // Soft reset held for 50 clocks.
    @(negedge clk); soft_rst_req = 1'b1;
    capture(60, -1, 49, -1);
    chk("s5 cpu_rst_n@3",  c_crst[3],  0);
    chk("s5 cpu_rst_n@30", c_crst[30], 0);
    chk("s5 cpu_ce@52",    c_cce[52],  1);
    chk("s5 cpu_rst_n@52", c_crst[52], 0);
    chk("s5 cpu_rst_n@53", c_crst[53], 1);
    chk("s5 sys_ready@53", c_rdy[53],  1);

    // Lock loss in CPU_RUN, then relock with a soft request during PPU_RUN.
    @(negedge clk); pll_locked = 1'b0;
    capture(5, -1, -1, -1);
    chk("s3 ppu_rst_n@1", c_prst[1], 1);
    chk("s3 ppu_rst_n@2", c_prst[2], 0);
    chk("s3 cpu_rst_n@2", c_crst[2], 0);
    chk("s3 ppu_ce@2",    c_pce[2],  0);
    chk("s3 phase@2",     c_ph[2],   0);
    @(negedge clk); pll_locked = 1'b1;
    capture(30, 14, 17, -1);
    check_clean_lock("s3relock");

    // Glitchy lock: a one-clock drop after the count reached 5.
    @(negedge clk); pll_locked = 1'b0;
    capture(6, -1, -1, -1);
    @(negedge clk); pll_locked = 1'b1;
    capture(32, -1, -1, 4);
    chk("s2 ppu_rst_n@11", c_prst[11], 0);
    chk("s2 ppu_rst_n@16", c_prst[16], 0);
    chk("s2 ppu_rst_n@17", c_prst[17], 1);
    chk("s2 cpu_rst_n@28", c_crst[28], 0);
    chk("s2 cpu_rst_n@29", c_crst[29], 1);

    // Asynchronous reset in the middle of CPU_HOLD.
    @(negedge clk); soft_rst_req = 1'b1;
    capture(4, -1, 0, -1);
    chk("s6 held cpu_rst_n@3", c_crst[3], 0);
    #1 rst_n = 1'b0;
    #1;
    chk("s6 async ppu_ce",    ppu_ce,    0);
    chk("s6 async cpu_ce",    cpu_ce,    0);
    chk("s6 async phase",     phase,     0);
    chk("s6 async ppu_rst_n", ppu_rst_n, 0);
    chk("s6 async cpu_rst_n", cpu_rst_n, 0);
    chk("s6 async sys_ready", sys_ready, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    capture(30, -1, -1, -1);
    check_clean_lock("s6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
